// File: rtl/fetch_operand_stage.sv
// fetch_operand_stage: fetch-operand (FOA) stage between fetch and execute.
// Accepts an instruction from fetch, decodes its 4-bit opcode, reads up to two
// operands from a single-port synchronous data memory (read data arrives the
// cycle after the strobe), and then presents the instruction and its operands
// to execute.
// Optional build macro: FOA_PERF_CNT_EN adds stall_cycles / instr_retired counters.
module fetch_operand_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DADDR_WIDTH = 14,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [ADDR_WIDTH-1:0]      pc_in,
  input  logic [4+2*DADDR_WIDTH-1:0] instr_in,
  input  logic                       flush,
  input  logic                       stall_in,
  output logic                       stall_out,
  output logic                       mem_rd_en,
  output logic [DADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  output logic                       valid_out,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic [3:0]                 opcode_out,
  output logic [DADDR_WIDTH-1:0]     a_out,
  output logic [DADDR_WIDTH-1:0]     b_out,
  output logic [DATA_WIDTH-1:0]      opa_out,
  output logic [DATA_WIDTH-1:0]      opb_out
`ifdef FOA_PERF_CNT_EN
  ,
  output logic [15:0]                stall_cycles,
  output logic [15:0]                instr_retired
`endif
);

  localparam int INSTR_WIDTH = 4 + 2 * DADDR_WIDTH;

  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SRLI = 4'd7;
  localparam logic [3:0] OP_CP   = 4'd10;
  localparam logic [3:0] OP_CPIM = 4'd11;  // CPi: immediate copy, no reads
  localparam logic [3:0] OP_CPI  = 4'd12;  // CPI: indirect read through mem[B]
  localparam logic [3:0] OP_JMP  = 4'd15;

  typedef enum logic [1:0] {IDLE, RD1, RD2, OUT} state_t;

  // Number of data-memory reads an opcode requires.
  function automatic logic [1:0] reads_needed(input logic [3:0] op);
    logic [1:0] n;
    case (op)
      OP_CPIM, OP_JMP:        n = 2'd0;
      OP_ADDI, OP_SRLI, OP_CP: n = 2'd1;
      default:                n = 2'd2;
    endcase
    return n;
  endfunction

  // Opcodes whose first read targets field B rather than field A.
  function automatic logic first_is_b(input logic [3:0] op);
    return (op == OP_CP) || (op == OP_CPI);
  endfunction

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    pc_reg;
  logic [3:0]               opcode_reg;
  logic [DADDR_WIDTH-1:0]   a_reg, b_reg;
  logic [DATA_WIDTH-1:0]    opa_reg, opb_reg;
  // The final read's data only arrives during the first OUT cycle, so these
  // flags route mem_rd_data straight to the output for that one cycle and
  // register it at the end of it.
  logic                     cap_a_reg, cap_b_reg;

  logic [3:0]               in_op;
  logic [DADDR_WIDTH-1:0]   in_a, in_b;
  logic                     accept;

  assign in_op  = instr_in[INSTR_WIDTH-1 -: 4];
  assign in_a   = instr_in[2*DADDR_WIDTH-1 -: DADDR_WIDTH];
  assign in_b   = instr_in[DADDR_WIDTH-1:0];
  assign accept = (state_reg == IDLE) && valid_in && !stall_in && !flush;

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (reads_needed(in_op) != 2'd0) ? RD1 : OUT;
      RD1:  state_next = (reads_needed(opcode_reg) == 2'd2) ? RD2 : OUT;
      RD2:  state_next = OUT;
      OUT:  if (!stall_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Memory strobe/address and stall request; all suppressed during flush or reset.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    stall_out   = 1'b0;
    if (!flush && !rst) begin
      case (state_reg)
        IDLE: stall_out = valid_in && (reads_needed(in_op) != 2'd0);
        RD1: begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = first_is_b(opcode_reg) ? b_reg : a_reg;
          stall_out   = 1'b1;
        end
        RD2: begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = (opcode_reg == OP_CPI) ? mem_rd_data[DADDR_WIDTH-1:0] : b_reg;
          stall_out   = 1'b1;
        end
        OUT:     stall_out = stall_in;
        default: stall_out = 1'b0;
      endcase
    end
  end

  // State, instruction latch and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= '0;
      opcode_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      cap_a_reg  <= 1'b0;
      cap_b_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cap_a_reg <= 1'b0;
      cap_b_reg <= 1'b0;
      if (!flush) begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              pc_reg     <= pc_in;
              opcode_reg <= in_op;
              a_reg      <= in_a;
              b_reg      <= in_b;
              opa_reg    <= '0;
              opb_reg    <= '0;
            end
          end
          RD1: begin
            if (reads_needed(opcode_reg) == 2'd1) begin
              if (first_is_b(opcode_reg)) cap_b_reg <= 1'b1;
              else                        cap_a_reg <= 1'b1;
            end
          end
          RD2: begin
            // First datum is an operand except for CPI, where it is only a pointer.
            if (opcode_reg != OP_CPI) opa_reg <= mem_rd_data;
            cap_b_reg <= 1'b1;
          end
          OUT: begin
            if (cap_a_reg) opa_reg <= mem_rd_data;
            if (cap_b_reg) opb_reg <= mem_rd_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign valid_out  = (state_reg == OUT);
  assign pc_out     = pc_reg;
  assign opcode_out = opcode_reg;
  assign a_out      = a_reg;
  assign b_out      = b_reg;
  assign opa_out    = cap_a_reg ? mem_rd_data : opa_reg;
  assign opb_out    = cap_b_reg ? mem_rd_data : opb_reg;

`ifdef FOA_PERF_CNT_EN
  logic [15:0] stall_cycles_reg;
  logic [15:0] instr_retired_reg;

  // Saturating stall-cycle counter and wrapping retirement counter; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg  <= '0;
      instr_retired_reg <= '0;
    end else begin
      if (stall_out && (stall_cycles_reg != 16'hFFFF))
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      if ((state_reg == OUT) && !stall_in && !flush)
        instr_retired_reg <= instr_retired_reg + 16'd1;
    end
  end

  assign stall_cycles  = stall_cycles_reg;
  assign instr_retired = instr_retired_reg;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_operand_stage.sv
// Self-checking bench for fetch_operand_stage: directed scenarios plus a
// randomized run checked against an opcode-level read-plan model.
module tb_fetch_operand_stage;
  localparam int AW = 10;
  localparam int DW = 14;
  localparam int XW = 32;
  localparam int IW = 4 + 2 * DW;

  logic          clk = 1'b0;
  logic          rst, valid_in, flush, stall_in;
  logic [AW-1:0] pc_in;
  logic [IW-1:0] instr_in;
  logic          stall_out, mem_rd_en, valid_out;
  logic [DW-1:0] mem_rd_addr, a_out, b_out;
  logic [XW-1:0] mem_rd_data, opa_out, opb_out;
  logic [AW-1:0] pc_out;
  logic [3:0]    opcode_out;
`ifdef FOA_PERF_CNT_EN
  logic [15:0]   stall_cycles, instr_retired;
`endif

  fetch_operand_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out),
    .a_out(a_out), .b_out(b_out), .opa_out(opa_out), .opb_out(opb_out)
`ifdef FOA_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .instr_retired(instr_retired)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port data memory: data valid the cycle after the strobe.
  logic [XW-1:0] mem [0:(1<<DW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int checks = 0;
  int failures = 0;

  // Observations of one issued instruction.
  int            obs_lat, obs_stall, obs_nrd;
  logic [DW-1:0] obs_rd [4];
  logic [XW-1:0] obs_opa, obs_opb;
  logic [AW-1:0] obs_pc;
  logic [3:0]    obs_op;
  logic [DW-1:0] obs_a, obs_b;

  // Reference expectations.
  int            exp_lat, exp_stall, exp_nrd;
  logic [DW-1:0] exp_rd [2];
  logic [XW-1:0] exp_opa, exp_opb;

  // Read plan per opcode, taken straight from the opcode table.
  task automatic model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [XW-1:0] ptr;
    exp_opa = '0; exp_opb = '0; exp_nrd = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    case (op)
      4'd11, 4'd15: exp_nrd = 0;
      4'd3, 4'd7: begin exp_nrd = 1; exp_rd[0] = a; exp_opa = mem[a]; end
      4'd10: begin exp_nrd = 1; exp_rd[0] = b; exp_opb = mem[b]; end
      4'd12: begin
        ptr = mem[b];
        exp_nrd = 2; exp_rd[0] = b; exp_rd[1] = ptr[DW-1:0];
        exp_opb = mem[ptr[DW-1:0]];
      end
      default: begin
        exp_nrd = 2; exp_rd[0] = a; exp_rd[1] = b;
        exp_opa = mem[a]; exp_opb = mem[b];
      end
    endcase
    exp_lat   = 1 + exp_nrd;
    exp_stall = (exp_nrd == 0) ? 0 : exp_nrd + 1;
  endtask

  // Present one instruction and watch until valid_out (bounded).
  task automatic issue(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
    obs_lat = -1; obs_stall = 0; obs_nrd = 0;
    @(negedge clk);
    valid_in = 1'b1; pc_in = pc; instr_in = instr; stall_in = 1'b0; flush = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(negedge clk); valid_in = 1'b0; end
      #1;
      if (stall_out) obs_stall++;
      if (mem_rd_en) begin
        if (obs_nrd < 4) obs_rd[obs_nrd] = mem_rd_addr;
        obs_nrd++;
      end
      if (valid_out) begin
        obs_lat = k; obs_opa = opa_out; obs_opb = opb_out; obs_pc = pc_out;
        obs_op = opcode_out; obs_a = a_out; obs_b = b_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; stall_in = 1'b0; pc_in = '0; instr_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    checks++; if ({pc_out, opcode_out, a_out, b_out, opa_out, opb_out, mem_rd_addr} !== '0) begin
      failures++; $display("FAIL reset_fields got pc=%h op=%h a=%h b=%h opa=%h opb=%h addr=%h exp all 0",
                           pc_out, opcode_out, a_out, b_out, opa_out, opb_out, mem_rd_addr); end
    $display("reset done: valid_out=%b stall_out=%b", valid_out, stall_out);
  endtask

  task automatic test_add();
    mem[5] = 32'd3; mem[6] = 32'd4;
    issue(10'h011, {4'd1, 14'd5, 14'd6});
    $display("ADD pc=011 lat=%0d stall=%0d reads=%0d opa=%0d opb=%0d", obs_lat, obs_stall, obs_nrd, obs_opa, obs_opb);
    checks++; if (obs_lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", obs_lat); end
    checks++; if (obs_nrd !== 2 || obs_rd[0] !== 14'd5 || obs_rd[1] !== 14'd6) begin
      failures++; $display("FAIL add_reads got n=%0d %0d,%0d exp 2 reads 5,6", obs_nrd, obs_rd[0], obs_rd[1]); end
    checks++; if (obs_opa !== 32'd3 || obs_opb !== 32'd4) begin
      failures++; $display("FAIL add_operands got=%0d,%0d exp=3,4", obs_opa, obs_opb); end
    checks++; if (obs_stall !== 3) begin failures++; $display("FAIL add_stall got=%0d exp=3", obs_stall); end
    checks++; if (obs_op !== 4'd1 || obs_pc !== 10'h011) begin
      failures++; $display("FAIL add_fields got op=%0d pc=%h exp op=1 pc=011", obs_op, obs_pc); end
`ifdef FOA_PERF_CNT_EN
    @(negedge clk); #1;
    checks++; if (stall_cycles !== 16'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
    checks++; if (instr_retired !== 16'd1) begin failures++; $display("FAIL perf_retired got=%0d exp=1", instr_retired); end
`endif
  endtask

  task automatic test_cp_imm();
    issue(10'h020, {4'd11, 14'd2, 14'h3F1});
    $display("CPi pc=020 lat=%0d stall=%0d reads=%0d", obs_lat, obs_stall, obs_nrd);
    checks++; if (obs_lat !== 1) begin failures++; $display("FAIL cpi_imm_latency got=%0d exp=1", obs_lat); end
    checks++; if (obs_stall !== 0 || obs_nrd !== 0) begin
      failures++; $display("FAIL cpi_imm_activity got stall=%0d reads=%0d exp 0,0", obs_stall, obs_nrd); end
    checks++; if (obs_opa !== 0 || obs_opb !== 0 || obs_a !== 14'd2 || obs_b !== 14'h3F1) begin
      failures++; $display("FAIL cpi_imm_out got opa=%h opb=%h a=%h b=%h exp 0,0,2,3f1", obs_opa, obs_opb, obs_a, obs_b); end
  endtask

  task automatic test_cp_indirect();
    mem[9] = 32'h20; mem[32'h20] = 32'hABCD;
    issue(10'h030, {4'd12, 14'd1, 14'd9});
    $display("CPI pc=030 lat=%0d reads=%0d opb=%h", obs_lat, obs_nrd, obs_opb);
    checks++; if (obs_nrd !== 2 || obs_rd[0] !== 14'd9 || obs_rd[1] !== 14'h20) begin
      failures++; $display("FAIL cpi_reads got n=%0d %h,%h exp 2 reads 9,20", obs_nrd, obs_rd[0], obs_rd[1]); end
    checks++; if (obs_opb !== 32'hABCD || obs_opa !== 0 || obs_lat !== 3) begin
      failures++; $display("FAIL cpi_out got opb=%h opa=%h lat=%0d exp abcd,0,3", obs_opb, obs_opa, obs_lat); end
  endtask

  task automatic test_out_stall();
    mem[14'h33] = 32'h1234_5678;
    issue(10'h044, {4'd3, 14'h33, 14'h7});
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      $display("ADDi hold cycle %0d valid=%b stall=%b opa=%h", i, valid_out, stall_out, opa_out);
      checks++; if (valid_out !== 1'b1 || stall_out !== 1'b1) begin
        failures++; $display("FAIL hold_ctrl cycle=%0d got valid=%b stall=%b exp 1,1", i, valid_out, stall_out); end
      checks++; if (opa_out !== 32'h1234_5678 || opb_out !== 0 || pc_out !== 10'h044 || opcode_out !== 4'd3 || a_out !== 14'h33) begin
        failures++; $display("FAIL hold_data cycle=%0d got opa=%h opb=%h pc=%h op=%h a=%h exp 12345678,0,044,3,33",
                             i, opa_out, opb_out, pc_out, opcode_out, a_out); end
    end
    @(negedge clk); stall_in = 1'b0; #1;
    checks++; if (valid_out !== 1'b1 || stall_out !== 1'b0) begin
      failures++; $display("FAIL hold_release got valid=%b stall=%b exp 1,0", valid_out, stall_out); end
    @(negedge clk); #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL hold_retire got valid=%b exp 0", valid_out); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    valid_in = 1'b1; pc_in = 10'h050; instr_in = {4'd8, 14'd100, 14'd200}; #1;
    @(negedge clk); valid_in = 1'b0; #1;
    checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 14'd100) begin
      failures++; $display("FAIL flush_rd1 got en=%b addr=%0d exp 1,100", mem_rd_en, mem_rd_addr); end
    @(negedge clk);
    flush = 1'b1; valid_in = 1'b1; pc_in = 10'h055; instr_in = {4'd15, 14'd7, 14'd9}; #1;
    checks++; if (mem_rd_en !== 1'b0 || stall_out !== 1'b0) begin
      failures++; $display("FAIL flush_cycle got en=%b stall=%b exp 0,0", mem_rd_en, stall_out); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_no_valid got=%b exp 0", valid_out); end
    @(negedge clk); valid_in = 1'b0; #1;
    $display("flush then JMP: valid=%b op=%0d pc=%h", valid_out, opcode_out, pc_out);
    checks++; if (valid_out !== 1'b1 || opcode_out !== 4'd15 || pc_out !== 10'h055 || opa_out !== 0 || opb_out !== 0) begin
      failures++; $display("FAIL flush_jmp got valid=%b op=%0d pc=%h opa=%h opb=%h exp 1,15,055,0,0",
                           valid_out, opcode_out, pc_out, opa_out, opb_out); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    valid_in = 1'b1; pc_in = 10'h066; instr_in = {4'd1, 14'd5, 14'd6}; #1;
    @(negedge clk); valid_in = 1'b0; rst = 1'b1; #1;
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_en got=%b exp 0", mem_rd_en); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (pc_out !== 0 || opa_out !== 0 || opb_out !== 0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL rst_mid_state got pc=%h opa=%h opb=%h en=%b exp all 0", pc_out, opa_out, opb_out, mem_rd_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_valid cycle=%0d got=%b exp 0", i, valid_out); end
    end
    $display("reset mid-read: valid=%b", valid_out);
  endtask

  task automatic test_random();
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    logic [AW-1:0] pc;
    for (int i = 0; i < 48; i++) begin
      op = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      a  = DW'($urandom); b = DW'($urandom); pc = AW'($urandom);
      model(op, a, b);
      issue(pc, {op, a, b});
      $display("rand %0d op=%0d pc=%h a=%h b=%h lat=%0d reads=%0d opa=%h opb=%h",
               i, op, pc, a, b, obs_lat, obs_nrd, obs_opa, obs_opb);
      checks++; if (obs_lat !== exp_lat || obs_stall !== exp_stall || obs_nrd !== exp_nrd) begin
        failures++; $display("FAIL rand_timing i=%0d got lat=%0d stall=%0d n=%0d exp %0d,%0d,%0d",
                             i, obs_lat, obs_stall, obs_nrd, exp_lat, exp_stall, exp_nrd); end
      if (exp_nrd >= 1) begin
        checks++; if (obs_rd[0] !== exp_rd[0]) begin failures++; $display("FAIL rand_rd0 i=%0d got=%h exp=%h", i, obs_rd[0], exp_rd[0]); end
      end
      if (exp_nrd == 2) begin
        checks++; if (obs_rd[1] !== exp_rd[1]) begin failures++; $display("FAIL rand_rd1 i=%0d got=%h exp=%h", i, obs_rd[1], exp_rd[1]); end
      end
      checks++; if (obs_opa !== exp_opa || obs_opb !== exp_opb) begin
        failures++; $display("FAIL rand_operands i=%0d got=%h,%h exp=%h,%h", i, obs_opa, obs_opb, exp_opa, exp_opb); end
      checks++; if (obs_op !== op || obs_pc !== pc || obs_a !== a || obs_b !== b) begin
        failures++; $display("FAIL rand_fields i=%0d got op=%h pc=%h a=%h b=%h exp %h,%h,%h,%h",
                             i, obs_op, obs_pc, obs_a, obs_b, op, pc, a, b); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << DW); i++) mem[i] = $urandom;
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; stall_in = 1'b0; pc_in = '0; instr_in = '0;
    test_reset();
    test_add();
    test_cp_imm();
    test_cp_indirect();
    test_out_stall();
    test_flush();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_operand_stage.md
Name: fetch_operand_stage

Overview:
- FOA stage: consumer end of the fetch-to-FOA interface.
- Accepts one instruction word plus PC per valid cycle from fetch and decodes the 4-bit opcode.
- Reads the required operands from the single-port synchronous data memory.
- Presents opcode, fields and operand values to execute.
- Drives the stall request back to fetch while operand reads are in progress.

Parameters:
- ADDR_WIDTH, 10, PC width.
- DADDR_WIDTH, 14, data-memory address width and width of fields A and B.
- DATA_WIDTH, 32, data word width; instruction word width is 4 + 2*DADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  instruction valid from fetch
- pc_in  in  ADDR_WIDTH  PC of the presented instruction
- instr_in  in  4+2*DADDR_WIDTH  instruction: opcode [top 4 bits], A [next DADDR_WIDTH bits], B [low DADDR_WIDTH bits]
- flush  in  1  kill the in-flight instruction
- stall_in  in  1  execute cannot accept
- stall_out  out  1  request to fetch to hold PC
- mem_rd_en  out  1  data-memory read strobe
- mem_rd_addr  out  DADDR_WIDTH  read address
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- valid_out  out  1  operands ready
- pc_out  out  ADDR_WIDTH  PC of the output instruction
- opcode_out  out  4  opcode
- a_out, b_out  out  DADDR_WIDTH each  raw A and B fields
- opa_out, opb_out  out  DATA_WIDTH each  fetched operand values

Behaviour:
- Opcodes: NAND=0, ADD=1, ADDF=2, ADDi=3, LT=4, LTF=5, SRL=6, SRLi=7, MUL=8, MULF=9, CP=10, CPi=11, CPI=12, CPIr=13, BZ=14, JMP=15.
- Read plan per opcode:
  - Two reads, mem[A] then mem[B]: NAND, ADD, ADDF, LT, LTF, SRL, MUL, MULF, CPIr, BZ.
  - mem[A] only: ADDi, SRLi.
  - mem[B] only: CP.
  - mem[B], then mem[that value's low DADDR_WIDTH bits] into opb_out: CPI.
  - No reads: CPi, JMP.
- Unread operand outputs are 0.
- FSM states: IDLE, RD1, RD2, OUT.
- IDLE:
  - Accepts when valid_in=1 and stall_in=0; latches pc, opcode, A and B.
  - Next state is RD1 if the opcode needs reads, else OUT.
- RD1:
  - mem_rd_en=1, mem_rd_addr = first address.
  - Next state RD2 when a second read is needed, else OUT.
- RD2:
  - Captures the first datum.
  - mem_rd_en=1 for the second address; for CPI the second address comes from the captured datum.
  - Next state OUT.
- Capture of the last datum happens on the cycle entering OUT.
- OUT:
  - valid_out=1.
  - With stall_in=0, the instruction retires; next state IDLE and valid_out drops next cycle.
  - With stall_in=1, all outputs hold.
- stall_out is combinational:
  - 1 when state is RD1, RD2, or OUT with stall_in=1.
  - 1 in IDLE when valid_in=1 and the opcode needs at least one read.
  - Else 0.
- Zero-read instructions: valid_out rises the cycle after acceptance (latency 1), with no stall.
- One-read latency: 2 cycles. Two-read latency: 3 cycles.
- valid_in while the FSM is not in IDLE is ignored; fetch holds PC and valid under stall, so no instruction is lost.
- flush has priority over every other event:
  - Next state IDLE, valid_out=0 next cycle.
  - Any pending capture is discarded.
  - mem_rd_en=0 in the flush cycle.
  - stall_out=0 in the flush cycle.
  - valid_in in the flush cycle is not accepted.
- Reset values: state IDLE; valid_out=0; mem_rd_en=0; pc_out, opcode_out, a_out, b_out, opa_out, opb_out and mem_rd_addr all 0.
- Reset mid-read abandons the read and suppresses capture the next cycle.

Optional Feature:
- Macro: FOA_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles (16 bits): counts cycles with stall_out=1 and saturates at 16'hFFFF.
  - Adds output instr_retired (16 bits): counts OUT-state retirements and wraps.
  - Both counters clear on reset; flush does not clear them.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then ADD A=5 B=6 with mem[5]=3, mem[6]=4:
  - Reads to 5 then 6.
  - valid_out at acceptance+3 with opa=3, opb=4.
  - stall_out high from the acceptance cycle for 3 cycles.
- CPi A=2 B=0x3F1: valid_out at +1, opa=opb=0, stall_out never high, no mem_rd_en.
- CPI B=9 with mem[9]=0x20 and mem[0x20]=0xABCD: reads to 9 then 0x20, opb_out=0xABCD.
- ADDi in OUT with stall_in=1 for 4 cycles: all outputs constant, stall_out=1; retires when stall_in drops.
- flush asserted during RD2 of MUL: valid_out stays 0, state returns to IDLE, next valid_in with JMP is accepted the following cycle.
- FOA_PERF_CNT_EN defined: the first scenario yields stall_cycles=3 and instr_retired=1.
